// File: rtl/des_decrypt_key_schedule.sv
// DES key schedule for decryption: emits K16..K1 one per handshake by rotating
// the PC-1 halves right, so no 16-entry subkey table is stored.
module des_decrypt_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_i,
    input  logic        key_valid_i,
    input  logic        subkey_ready_i,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    output logic [3:0]  round_idx_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {StIdle, StPresent, StDone} state_e;

    // DES bit numbers (1 = MSB) selected by each output position, first entry first.
    localparam int unsigned Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned Pc2Tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) begin
            r[55 - j] = k[64 - Pc1Tab[j]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47 - j] = cd[56 - Pc2Tab[j]];
        end
        return r;
    endfunction

    function automatic logic [27:0] ror1(input logic [27:0] x);
        return {x[0], x[27:1]};
    endfunction

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        one_shift;

    // Decryption rounds 0, 7 and 14 step back over an encryption shift of one.
    assign one_shift = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

    // Next-state: load on accept, rotate right on each handshake, clear counter at the end.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                if (key_valid_i) begin
                    {c_d, d_d} = pc1(key_i);
                    round_d    = 4'd0;
                    state_d    = StPresent;
                end
            end
            StPresent: begin
                if (subkey_ready_i) begin
                    if (round_q == 4'd15) begin
                        round_d = 4'd0;
                        state_d = StDone;
                    end else begin
                        c_d     = one_shift ? ror1(c_q) : ror1(ror1(c_q));
                        d_d     = one_shift ? ror1(d_q) : ror1(ror1(d_q));
                        round_d = round_q + 4'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
        end
    end

    // Outputs are decoded from state only; subkey is PC-2 of the live halves.
    always_comb begin
        subkey_o       = pc2({c_q, d_q});
        subkey_valid_o = (state_q == StPresent);
        round_idx_o    = round_q;
        busy_o         = (state_q != StIdle);
        done_o         = (state_q == StDone);
    end

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Self-checking bench: DUT subkeys against a bit-level encryption key schedule
// (left shifts, K1..K16) that is then read back in reverse order.
module tb_des_decrypt_key_schedule;

    logic        clk;
    logic        rst;
    logic [63:0] key_i;
    logic        key_valid_i;
    logic        subkey_ready_i;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic [3:0]  round_idx_o;
    logic        busy_o;
    logic        done_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [47:0] exp_keys [16];

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_decrypt_key_schedule dut (
        .clk            (clk),
        .rst            (rst),
        .key_i          (key_i),
        .key_valid_i    (key_valid_i),
        .subkey_ready_i (subkey_ready_i),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .round_idx_o    (round_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Encryption schedule K1..K16 by left rotation; decryption round r uses K(16-r).
    task automatic compute_ref(input logic [63:0] k);
        bit          kb [1:64];
        bit          c  [1:28];
        bit          d  [1:28];
        bit          cd [1:56];
        bit          tc, td;
        logic [47:0] ks;
        for (int i = 1; i <= 64; i++) kb[i] = k[64 - i];
        for (int j = 1; j <= 28; j++) begin
            c[j] = kb[PC1_T[j - 1]];
            d[j] = kb[PC1_T[j + 27]];
        end
        for (int n = 1; n <= 16; n++) begin
            for (int s = 0; s < SHIFTS[n - 1]; s++) begin
                tc = c[1];
                td = d[1];
                for (int i = 1; i < 28; i++) begin
                    c[i] = c[i + 1];
                    d[i] = d[i + 1];
                end
                c[28] = tc;
                d[28] = td;
            end
            for (int i = 1; i <= 28; i++) begin
                cd[i]      = c[i];
                cd[i + 28] = d[i];
            end
            ks = '0;
            for (int j = 1; j <= 48; j++) ks[48 - j] = cd[PC2_T[j - 1]];
            exp_keys[16 - n] = ks;
        end
    endtask

    // Runs one schedule from IDLE (entered and left at a falling edge). Optionally
    // raises key_valid with another key at round noise_round and during DONE.
    task automatic run_sched(input logic [63:0] ref_key, input logic [63:0] drv_key,
                             input int stall_pct, input int noise_round,
                             input logic [63:0] noise_key, input string tag);
        int r;
        int guard;
        compute_ref(ref_key);
        key_i          = drv_key;
        key_valid_i    = 1'b1;
        subkey_ready_i = 1'b0;
        @(negedge clk);
        key_valid_i = 1'b0;
        r     = 0;
        guard = 0;
        while (r < 16 && guard < 400) begin
            n_total++;
            if (subkey_valid_o !== 1'b1)
                $display("FAIL %s valid r=%0d: got %b want 1", tag, r, subkey_valid_o);
            else n_pass++;
            n_total++;
            if (round_idx_o !== 4'(r))
                $display("FAIL %s round_idx: got %0d want %0d", tag, round_idx_o, r);
            else n_pass++;
            n_total++;
            if (subkey_o !== exp_keys[r])
                $display("FAIL %s subkey r=%0d: got %h want %h", tag, r, subkey_o, exp_keys[r]);
            else n_pass++;
            subkey_ready_i = (int'($urandom_range(99)) >= stall_pct);
            key_valid_i    = (r == noise_round);
            key_i          = (r == noise_round) ? noise_key : drv_key;
            @(negedge clk);
            guard++;
            if (subkey_ready_i) r++;
        end
        n_total++;
        if (guard >= 400) $display("FAIL %s timeout: got %0d rounds want 16", tag, r);
        else n_pass++;
        subkey_ready_i = 1'b0;
        key_valid_i    = (noise_round >= 0);
        key_i          = noise_key;
        n_total++;
        if ({done_o, subkey_valid_o, busy_o} !== 3'b101)
            $display("FAIL %s done cycle: got done/valid/busy=%b want 101", tag,
                     {done_o, subkey_valid_o, busy_o});
        else n_pass++;
        @(negedge clk);
        key_valid_i = 1'b0;
        n_total++;
        if ({done_o, subkey_valid_o, busy_o, round_idx_o} !== 7'b0)
            $display("FAIL %s idle after done: got done/valid/busy/idx=%b want 0", tag,
                     {done_o, subkey_valid_o, busy_o, round_idx_o});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_i = '0;
        key_valid_i = 1'b0;
        subkey_ready_i = 1'b0;
        #1;
        n_total++;
        if ({busy_o, done_o, subkey_valid_o} !== 3'b000)
            $display("FAIL reset flags: got busy/done/valid=%b want 000",
                     {busy_o, done_o, subkey_valid_o});
        else n_pass++;
        n_total++;
        if (subkey_o !== 48'h0) $display("FAIL reset subkey: got %h want 0", subkey_o);
        else n_pass++;
        n_total++;
        if (round_idx_o !== 4'd0) $display("FAIL reset round_idx: got %0d want 0", round_idx_o);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL reset idle busy: got %b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_known_vector();
        key_i          = 64'h133457799BBCDFF1;
        key_valid_i    = 1'b1;
        subkey_ready_i = 1'b1;
        @(negedge clk);
        key_valid_i = 1'b0;
        n_total++;
        if (subkey_o !== 48'hCB3D8B0E17F5 || round_idx_o !== 4'd0)
            $display("FAIL kv first: got %h/%0d want cb3d8b0e17f5/0", subkey_o, round_idx_o);
        else n_pass++;
        for (int i = 0; i < 15; i++) @(negedge clk);
        n_total++;
        if (subkey_o !== 48'h1B02EFFC7072 || round_idx_o !== 4'd15)
            $display("FAIL kv last: got %h/%0d want 1b02effc7072/15", subkey_o, round_idx_o);
        else n_pass++;
        @(negedge clk);
        subkey_ready_i = 1'b0;
        n_total++;
        if (done_o !== 1'b1) $display("FAIL kv done: got %b want 1", done_o);
        else n_pass++;
        @(negedge clk);
        run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 0, -1, '0, "kv_full");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++)
            run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 50, -1, '0, "stall");
    endtask

    task automatic test_random_keys();
        logic [63:0] k;
        for (int i = 0; i < 100; i++) begin
            k = {$urandom, $urandom};
            run_sched(k, k, 25, -1, '0, "rand");
            run_sched(k, k ^ 64'h0101010101010101, 0, -1, '0, "parity");
        end
    endtask

    task automatic test_ignore_busy();
        logic [63:0] k1;
        k1 = {$urandom, $urandom};
        run_sched(k1, k1, 20, 5, ~k1, "ignore");
    endtask

    task automatic test_reset_mid();
        logic [63:0] k1;
        logic [63:0] k2;
        int          bad;
        k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        compute_ref(k1);
        key_i          = k1;
        key_valid_i    = 1'b1;
        subkey_ready_i = 1'b1;
        @(negedge clk);
        key_valid_i = 1'b0;
        for (int r = 0; r < 9; r++) @(negedge clk);
        n_total++;
        if (round_idx_o !== 4'd9 || subkey_o !== exp_keys[9])
            $display("FAIL rstmid pre: got %h/%0d want %h/9", subkey_o, round_idx_o, exp_keys[9]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy_o, done_o, subkey_valid_o, round_idx_o} !== 7'b0 || subkey_o !== 48'h0)
            $display("FAIL rstmid async: got flags=%b subkey=%h want 0",
                     {busy_o, done_o, subkey_valid_o, round_idx_o}, subkey_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o !== 1'b0 || subkey_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL rstmid stays idle: got %0d bad cycles want 0", bad);
        else n_pass++;
        // key_valid while rst is high must not start a schedule
        rst         = 1'b1;
        key_i       = k2;
        key_valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL rstmid accept in reset: got busy=%b want 0", busy_o);
        else n_pass++;
        rst = 1'b0;
        run_sched(k2, k2, 10, -1, '0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [63:0] k;
        int          first_done;
        int          prev_done;
        int          n_done;
        int          n_idle;
        int          bad;
        int          bad_sk;
        k = {$urandom, $urandom};
        compute_ref(k);
        key_i          = k;
        key_valid_i    = 1'b1;
        subkey_ready_i = 1'b1;
        first_done = -1;
        prev_done  = -1;
        n_done = 0;
        n_idle = 0;
        bad    = 0;
        bad_sk = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (prev_done >= 0 && i - prev_done != 18) bad++;
                if (first_done < 0) first_done = i;
                prev_done = i;
                n_done++;
            end
            if (busy_o === 1'b0) begin
                n_idle++;
                if (!(prev_done >= 0 && i == prev_done + 1)) bad++;
            end
            if (subkey_valid_o === 1'b1 && subkey_o !== exp_keys[round_idx_o]) bad_sk++;
        end
        n_total++;
        if (first_done != 16) $display("FAIL b2b first done: got %0d want 16", first_done);
        else n_pass++;
        n_total++;
        if (n_done != 3) $display("FAIL b2b done count: got %0d want 3", n_done);
        else n_pass++;
        n_total++;
        if (n_idle != 3) $display("FAIL b2b idle count: got %0d want 3", n_idle);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL b2b spacing: got %0d bad events want 0", bad);
        else n_pass++;
        n_total++;
        if (bad_sk != 0) $display("FAIL b2b subkeys: got %0d wrong want 0", bad_sk);
        else n_pass++;
        key_valid_i    = 1'b0;
        subkey_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_stall();
        test_random_keys();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/des_decrypt_key_schedule.md
DES_DECRYPT_KEY_SCHEDULE -- requirements
Module: des_decrypt_key_schedule

Interface
REQ-001 Parameters: none; all widths fixed by DES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 key  input  64  DES key; DES bit 1 = key[63]; parity bits (8,16,..,64) ignored.
REQ-005 key_valid  input  1  load request; sampled only when busy=0.
REQ-006 subkey  output  48  current decryption subkey; DES bit 1 = subkey[47].
REQ-007 subkey_valid  output  1  subkey holds a valid round key.
REQ-008 subkey_ready  input  1  consumer accepts subkey when subkey_valid & subkey_ready.
REQ-009 round_idx  output  4  decryption round of presented subkey, 0..15 (0 = first round, carries K16).
REQ-010 busy  output  1  schedule in progress; key_valid ignored while high.
REQ-011 done  output  1  one-cycle pulse after 16th subkey accepted.

Function
REQ-012 Block SHALL generate the 16 DES subkeys in decryption order K16, K15, ..., K1 using right circular shifts of 28-bit C/D halves; no stored 16-entry table.
REQ-013 On accept (key_valid=1, busy=0): C,D registers load PC-1(key) (C = PC-1 bits 1..28, D = bits 29..56); round counter loads 0; busy=1 next cycle.
REQ-014 States: IDLE, PRESENT, DONE.
REQ-015 IDLE -> PRESENT on accept; PRESENT -> PRESENT on handshake with round_idx<15; PRESENT -> DONE on handshake with round_idx=15; DONE -> IDLE unconditionally after one cycle.
REQ-016 In PRESENT: subkey_valid=1, subkey = PC-2(C||D) combinationally from current C,D registers.
REQ-017 Latency: subkey for round 0 valid in first cycle after accept (1 cycle); each later subkey valid in cycle after previous handshake.
REQ-018 Round 0 uses unshifted PC-1 halves (K16 = PC-2(C0||D0)).
REQ-019 On handshake at round_idx r (r<15), C and D each rotate right by S(r+1), then round counter increments; S(1)=1, S(2..7)=2, S(8)=1, S(9..14)=2, S(15)=1 (total 27).
REQ-020 Right rotate by 1: new[27] = old[0], new[26:0] = old[27:1]; by 2: two such rotations in one cycle.
REQ-021 No handshake (subkey_ready=0): subkey, round_idx, C, D held stable; subkey_valid stays 1.
REQ-022 subkey_ready ignored when subkey_valid=0.
REQ-023 DONE: subkey_valid=0, done=1, busy=1 for exactly that cycle; IDLE next cycle, busy=0.
REQ-024 key_valid during busy (PRESENT or DONE) SHALL be dropped, not queued; earliest new accept is first IDLE cycle.
REQ-025 key_valid held high continuously: new schedule starts on each IDLE cycle (back-to-back schedules separated by DONE+IDLE).
REQ-026 In IDLE: subkey_valid=0, round_idx=0, subkey value don't-care but SHALL not be X after reset.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, C=0, D=0, round counter 0, subkey_valid=0, busy=0, done=0, subkey=PC-2(0)=0.
REQ-028 rst asserted mid-schedule SHALL abort it; no done pulse; after release block waits in IDLE for new key_valid.
REQ-029 key_valid in cycle rst deasserts SHALL be accepted only if rst is low at that clock edge.

Verification
REQ-030 key=0x133457799BBCDFF1, key_valid 1 cycle, subkey_ready=1 -> next cycle subkey=0xCB3D8B0E17F5, round_idx=0; 16th subkey=0x1B02EFFC7072, round_idx=15; done next cycle.
REQ-031 Same key, subkey_ready toggled randomly -> identical 16-subkey sequence, each held stable while ready=0; total cycles = 1 + 16 + stall cycles + 1 (DONE).
REQ-032 Compare all 16 outputs for 100 random keys against reference model of encryption schedule reversed (K16..K1); also flip parity bits -> identical subkeys.
REQ-033 Second key_valid at round_idx=5 with different key -> ignored; sequence for first key completes unchanged.
REQ-034 rst pulse at round_idx=9 -> outputs at reset values same cycle (async), no done; new key after release produces full correct sequence from round_idx=0.
REQ-035 key_valid tied high, ready=1 -> back-to-back schedules, done pulse every 18 cycles, busy low exactly one cycle between.
